// File: rtl/decode_queue.sv
// decode_queue: decodes raw instructions at enqueue and buffers them in a DEPTH-entry ring for issue.
// Optional macro DECODE_MUL_EN: enables MUL decode; when undefined, MUL encodings raise illegal-instruction.
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_instr,
    input  logic [XLEN-1:0]              in_pc,
    input  logic                         in_supervisor_mode,
    input  logic [2:0]                   in_exception_vector,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [XLEN-1:0]              out_pc,
    output logic [4:0]                   out_rs1,
    output logic [4:0]                   out_rs2,
    output logic [4:0]                   out_rd,
    output logic [6:0]                   out_funct7,
    output logic [2:0]                   out_funct3,
    output logic [6:0]                   out_opcode,
    output logic [31:0]                  out_imm,
    output logic [2:0]                   out_instr_type,
    output logic [2:0]                   out_exception_vector,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_NOP      = 7'b0001011;
    localparam logic [6:0] OPC_ALU_IMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_TLBWRITE = 7'b0101011;
    localparam logic [6:0] OPC_ALU      = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JUMP     = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] IRET_FUNCT3  = 3'b000;
    localparam logic [2:0] MOVRM_FUNCT3 = 3'b001;
    localparam logic [6:0] MUL_FUNCT7   = 7'b0000001;

    localparam logic [2:0] INSTR_TYPE_ALU      = 3'd0;
    localparam logic [2:0] INSTR_TYPE_MUL      = 3'd1;
    localparam logic [2:0] INSTR_TYPE_LOAD     = 3'd2;
    localparam logic [2:0] INSTR_TYPE_STORE    = 3'd3;
    localparam logic [2:0] INSTR_TYPE_NO_WB    = 3'd4;
    localparam logic [2:0] INSTR_TYPE_IRET     = 3'd5;
    localparam logic [2:0] INSTR_TYPE_MOVRM    = 3'd6;
    localparam logic [2:0] INSTR_TYPE_TLBWRITE = 3'd7;

    function automatic logic [31:0] imm_gen(input logic [31:0] instr);
        logic [31:0] imm;
        case (instr[6:0])
            OPC_LOAD, OPC_ALU_IMM: imm = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:             imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:            imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OPC_AUIPC, OPC_LUI:    imm = {instr[31:12], 12'h000};
            default:               imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        endcase
        return imm;
    endfunction

    function automatic logic opcode_known(input logic [6:0] opc);
        logic known;
        case (opc)
            OPC_ALU, OPC_ALU_IMM, OPC_BRANCH, OPC_STORE, OPC_LOAD, OPC_JUMP,
            OPC_AUIPC, OPC_LUI, OPC_NOP, OPC_SYSTEM, OPC_TLBWRITE: known = 1'b1;
            default:                                               known = 1'b0;
        endcase
        return known;
    endfunction

    logic [XLEN-1:0] pc_q    [DEPTH];
    logic [31:0]     instr_q [DEPTH];
    logic [31:0]     imm_q   [DEPTH];
    logic [2:0]      type_q  [DEPTH];
    logic [2:0]      exc_q   [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic        enq_s;
    logic        deq_s;
    logic [6:0]  dec_opcode_s;
    logic [2:0]  dec_funct3_s;
    logic [6:0]  dec_funct7_s;
    logic        dec_system_s;
    logic        mul_enc_s;
    logic [31:0] dec_imm_s;
    logic [2:0]  dec_exc_s;
    logic [2:0]  dec_type_s;

    // Combinational decode of the incoming fetch instruction.
    always_comb begin
        dec_opcode_s = in_instr[6:0];
        dec_funct3_s = in_instr[14:12];
        dec_funct7_s = in_instr[31:25];
        dec_system_s = (dec_opcode_s == OPC_SYSTEM);
        mul_enc_s    = (dec_opcode_s == OPC_ALU) && (dec_funct7_s == MUL_FUNCT7);
        dec_imm_s    = imm_gen(in_instr);

        dec_exc_s[2] = (dec_system_s && !in_supervisor_mode) || in_exception_vector[2];
`ifdef DECODE_MUL_EN
        dec_exc_s[1] = !opcode_known(dec_opcode_s) || in_exception_vector[1];
`else
        dec_exc_s[1] = !opcode_known(dec_opcode_s) || mul_enc_s || in_exception_vector[1];
`endif
        dec_exc_s[0] = in_exception_vector[0];

        // Any faulting entry must never write back, regardless of its opcode.
        if (dec_exc_s != 3'b000) begin
            dec_type_s = INSTR_TYPE_NO_WB;
        end else if (dec_system_s && (dec_funct3_s == IRET_FUNCT3)) begin
            dec_type_s = INSTR_TYPE_IRET;
        end else if (dec_system_s && (dec_funct3_s == MOVRM_FUNCT3)) begin
            dec_type_s = INSTR_TYPE_MOVRM;
        end else if (dec_opcode_s == OPC_TLBWRITE) begin
            dec_type_s = INSTR_TYPE_TLBWRITE;
`ifdef DECODE_MUL_EN
        end else if (mul_enc_s) begin
            dec_type_s = INSTR_TYPE_MUL;
`endif
        end else if ((dec_opcode_s == OPC_ALU) || (dec_opcode_s == OPC_AUIPC) ||
                     (dec_opcode_s == OPC_ALU_IMM) || (dec_opcode_s == OPC_NOP)) begin
            dec_type_s = INSTR_TYPE_ALU;
        end else if ((dec_opcode_s == OPC_LOAD) || (dec_opcode_s == OPC_LUI)) begin
            dec_type_s = INSTR_TYPE_LOAD;
        end else if (dec_opcode_s == OPC_STORE) begin
            dec_type_s = INSTR_TYPE_STORE;
        end else begin
            dec_type_s = INSTR_TYPE_NO_WB;
        end
    end

    // in_ready depends only on registered occupancy, so a full queue rejects input even while draining.
    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != {CW{1'b0}});
    assign enq_s     = in_valid && in_ready;
    assign deq_s     = out_valid && out_ready;

    // Next-state for pointers and occupancy; flush discards both handshakes.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (enq_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (deq_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({enq_s, deq_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage: cleared only by reset, written on an accepted non-flushed enqueue.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= {XLEN{1'b0}};
                instr_q[i] <= 32'h0000_0000;
                imm_q[i]   <= 32'h0000_0000;
                type_q[i]  <= 3'b000;
                exc_q[i]   <= 3'b000;
            end
        end else if (enq_s && !flush) begin
            pc_q[wr_ptr_q]    <= in_pc;
            instr_q[wr_ptr_q] <= in_instr;
            imm_q[wr_ptr_q]   <= dec_imm_s;
            type_q[wr_ptr_q]  <= dec_type_s;
            exc_q[wr_ptr_q]   <= dec_exc_s;
        end
    end

    assign out_pc               = pc_q[rd_ptr_q];
    assign out_rs1              = instr_q[rd_ptr_q][19:15];
    assign out_rs2              = instr_q[rd_ptr_q][24:20];
    assign out_rd               = instr_q[rd_ptr_q][11:7];
    assign out_funct7           = instr_q[rd_ptr_q][31:25];
    assign out_funct3           = instr_q[rd_ptr_q][14:12];
    assign out_opcode           = instr_q[rd_ptr_q][6:0];
    assign out_imm              = imm_q[rd_ptr_q];
    assign out_instr_type       = type_q[rd_ptr_q];
    assign out_exception_vector = exc_q[rd_ptr_q];
    assign count                = count_q;

endmodule

// File: tb/tb_decode_queue.sv
// Directed self-checking bench for decode_queue (DEPTH = 4); honours DECODE_MUL_EN if defined.
module tb_decode_queue;

    localparam logic [2:0] T_ALU   = 3'd0;
    localparam logic [2:0] T_MUL   = 3'd1;
    localparam logic [2:0] T_LOAD  = 3'd2;
    localparam logic [2:0] T_STORE = 3'd3;
    localparam logic [2:0] T_NOWB  = 3'd4;
    localparam logic [2:0] T_IRET  = 3'd5;
    localparam logic [2:0] T_MOVRM = 3'd6;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, in_supervisor_mode;
    logic [31:0] in_instr, in_pc;
    logic [2:0]  in_exception_vector;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_imm;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [6:0]  out_funct7, out_opcode;
    logic [2:0]  out_funct3, out_instr_type, out_exception_vector;
    logic [2:0]  count;

    int checks = 0;
    int fails  = 0;

    decode_queue #(.DEPTH(4), .XLEN(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .in_supervisor_mode(in_supervisor_mode), .in_exception_vector(in_exception_vector),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_funct7(out_funct7), .out_funct3(out_funct3), .out_opcode(out_opcode),
        .out_imm(out_imm), .out_instr_type(out_instr_type),
        .out_exception_vector(out_exception_vector), .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [31:0] instr, input logic [31:0] pc,
                       input logic sup, input logic [2:0] exc);
        in_valid = 1'b1; in_instr = instr; in_pc = pc;
        in_supervisor_mode = sup; in_exception_vector = exc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic deq();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'h0; in_pc = 32'h0; in_supervisor_mode = 1'b0; in_exception_vector = 3'b000;
        tick(); tick();
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if ({out_pc, out_imm} !== 64'h0) begin fails++; $display("FAIL reset_pc_imm: got %h %h want 0 0", out_pc, out_imm); end
        checks++; if ({out_instr_type, out_exception_vector, out_opcode, out_rd} !== 18'h0) begin
            fails++; $display("FAIL reset_fields: got type %h exc %h opc %h rd %h want 0", out_instr_type, out_exception_vector, out_opcode, out_rd); end
    endtask

    task automatic test_addi();
        enq(32'h0050_0093, 32'h0000_0100, 1'b0, 3'b000);
        checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL addi_valid: got %b want 1", out_valid); end
        checks++; if (out_instr_type !== T_ALU) begin fails++; $display("FAIL addi_type: got %0d want %0d", out_instr_type, T_ALU); end
        checks++; if (out_imm !== 32'd5) begin fails++; $display("FAIL addi_imm: got %h want 5", out_imm); end
        checks++; if (out_rd !== 5'd1) begin fails++; $display("FAIL addi_rd: got %0d want 1", out_rd); end
        checks++; if (out_exception_vector !== 3'b000) begin fails++; $display("FAIL addi_exc: got %b want 000", out_exception_vector); end
        checks++; if (out_pc !== 32'h100) begin fails++; $display("FAIL addi_pc: got %h want 100", out_pc); end
        checks++; if (count !== 3'd1) begin fails++; $display("FAIL addi_count: got %0d want 1", count); end
        deq();
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL addi_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_decode_formats();
        enq(32'h0020_A423, 32'h0000_0110, 1'b0, 3'b000);   // sw x2, 8(x1)
        checks++; if ({out_instr_type, out_imm} !== {T_STORE, 32'd8}) begin fails++; $display("FAIL sw_decode: got type %0d imm %h want 3 8", out_instr_type, out_imm); end
        checks++; if ({out_rs1, out_rs2, out_funct3} !== {5'd1, 5'd2, 3'd2}) begin fails++; $display("FAIL sw_fields: got rs1 %0d rs2 %0d f3 %0d want 1 2 2", out_rs1, out_rs2, out_funct3); end
        deq();
        enq(32'hFE00_0EE3, 32'h0000_0114, 1'b0, 3'b000);   // beq x0, x0, -4
        checks++; if ({out_instr_type, out_imm} !== {T_NOWB, 32'hFFFF_FFFC}) begin fails++; $display("FAIL beq_decode: got type %0d imm %h want 4 fffffffc", out_instr_type, out_imm); end
        deq();
        enq(32'h1234_52B7, 32'h0000_0118, 1'b0, 3'b000);   // lui x5, 0x12345
        checks++; if ({out_instr_type, out_imm, out_rd} !== {T_LOAD, 32'h1234_5000, 5'd5}) begin fails++; $display("FAIL lui_decode: got type %0d imm %h rd %0d want 2 12345000 5", out_instr_type, out_imm, out_rd); end
        deq();
        enq(32'h0080_00EF, 32'h0000_011C, 1'b0, 3'b000);   // jal x1, 8
        checks++; if ({out_instr_type, out_imm} !== {T_NOWB, 32'd8}) begin fails++; $display("FAIL jal_decode: got type %0d imm %h want 4 8", out_instr_type, out_imm); end
        deq();
    endtask

    task automatic test_fill_wrap();
        for (int i = 0; i < 4; i++) enq(32'h0050_0093, 32'h200 + 32'(4 * i), 1'b0, 3'b000);
        checks++; if (count !== 3'd4) begin fails++; $display("FAIL full_count: got %0d want 4", count); end
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
        // full: a simultaneous dequeue must not let this enqueue in
        in_valid = 1'b1; in_pc = 32'h999; out_ready = 1'b1;
        checks++; if (out_pc !== 32'h200) begin fails++; $display("FAIL full_head: got %h want 200", out_pc); end
        tick();
        in_valid = 1'b0;
        checks++; if (count !== 3'd3) begin fails++; $display("FAIL full_deq_count: got %0d want 3", count); end
        for (int i = 1; i < 4; i++) begin
            checks++; if (out_pc !== 32'h200 + 32'(4 * i)) begin fails++; $display("FAIL drain_order: got %h want %h", out_pc, 32'h200 + 32'(4 * i)); end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (count !== 3'd0) begin fails++; $display("FAIL drain_count: got %0d want 0", count); end
        for (int i = 0; i < 3; i++) enq(32'h0050_0093, 32'h300 + 32'(4 * i), 1'b0, 3'b000);
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_pc !== 32'h300 + 32'(4 * i)) begin fails++; $display("FAIL wrap_order: got %h want %h", out_pc, 32'h300 + 32'(4 * i)); end
            deq();
        end
    endtask

    task automatic test_back_to_back();
        enq(32'h0050_0093, 32'h400, 1'b0, 3'b000);
        enq(32'h0050_0093, 32'h404, 1'b0, 3'b000);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_pc = 32'h408 + 32'(4 * i); out_ready = 1'b1;
            checks++; if (out_pc !== 32'h400 + 32'(4 * i)) begin fails++; $display("FAIL b2b_head: got %h want %h", out_pc, 32'h400 + 32'(4 * i)); end
            tick();
            checks++; if (count !== 3'd2) begin fails++; $display("FAIL b2b_count: got %0d want 2", count); end
        end
        in_valid = 1'b0;
        checks++; if (out_pc !== 32'h428) begin fails++; $display("FAIL b2b_tail0: got %h want 428", out_pc); end
        tick();
        checks++; if (out_pc !== 32'h42C) begin fails++; $display("FAIL b2b_tail1: got %h want 42c", out_pc); end
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_empty: got %b want 0", out_valid); end
    endtask

    task automatic test_system();
        enq(32'h0000_0073, 32'h500, 1'b0, 3'b000);
        checks++; if ({out_exception_vector, out_instr_type} !== {3'b100, T_NOWB}) begin fails++; $display("FAIL sys_user: got exc %b type %0d want 100 4", out_exception_vector, out_instr_type); end
        deq();
        enq(32'h0000_0073, 32'h504, 1'b1, 3'b000);
        checks++; if ({out_exception_vector, out_instr_type} !== {3'b000, T_IRET}) begin fails++; $display("FAIL sys_iret: got exc %b type %0d want 000 5", out_exception_vector, out_instr_type); end
        deq();
        enq(32'h0000_1073, 32'h508, 1'b1, 3'b000);
        checks++; if ({out_exception_vector, out_instr_type} !== {3'b000, T_MOVRM}) begin fails++; $display("FAIL sys_movrm: got exc %b type %0d want 000 6", out_exception_vector, out_instr_type); end
        deq();
    endtask

    task automatic test_exceptions();
        enq(32'h0000_007F, 32'h520, 1'b1, 3'b000);
        checks++; if ({out_exception_vector, out_instr_type} !== {3'b010, T_NOWB}) begin fails++; $display("FAIL illegal_op: got exc %b type %0d want 010 4", out_exception_vector, out_instr_type); end
        deq();
        enq(32'h0050_0093, 32'h524, 1'b0, 3'b001);
        checks++; if ({out_exception_vector, out_instr_type} !== {3'b001, T_NOWB}) begin fails++; $display("FAIL fetch_fault: got exc %b type %0d want 001 4", out_exception_vector, out_instr_type); end
        deq();
        enq(32'h0050_0093, 32'h528, 1'b0, 3'b100);
        checks++; if ({out_exception_vector, out_instr_type} !== {3'b100, T_NOWB}) begin fails++; $display("FAIL fetch_priv: got exc %b type %0d want 100 4", out_exception_vector, out_instr_type); end
        deq();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) enq(32'h0050_0093, 32'h600 + 32'(4 * i), 1'b0, 3'b000);
        checks++; if (count !== 3'd3) begin fails++; $display("FAIL flush_pre: got %0d want 3", count); end
        flush = 1'b1; in_valid = 1'b1; in_pc = 32'hDEAD;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if ({count, out_valid, in_ready} !== {3'd0, 1'b0, 1'b1}) begin fails++; $display("FAIL flush_state: got count %0d valid %b ready %b want 0 0 1", count, out_valid, in_ready); end
        enq(32'h0050_0093, 32'h700, 1'b0, 3'b000);
        checks++; if ({out_pc, count} !== {32'h700, 3'd1}) begin fails++; $display("FAIL flush_after: got pc %h count %0d want 700 1", out_pc, count); end
        deq();
    endtask

    task automatic test_mul();
        enq(32'h0220_81B3, 32'h800, 1'b0, 3'b000);          // mul x3, x1, x2
`ifdef DECODE_MUL_EN
        checks++; if ({out_exception_vector, out_instr_type} !== {3'b000, T_MUL}) begin fails++; $display("FAIL mul_decode: got exc %b type %0d want 000 1", out_exception_vector, out_instr_type); end
`else
        checks++; if ({out_exception_vector, out_instr_type} !== {3'b010, T_NOWB}) begin fails++; $display("FAIL mul_decode: got exc %b type %0d want 010 4", out_exception_vector, out_instr_type); end
`endif
        deq();
        enq(32'h4020_81B3, 32'h804, 1'b0, 3'b000);          // sub x3, x1, x2
        checks++; if ({out_exception_vector, out_instr_type, out_funct7} !== {3'b000, T_ALU, 7'h20}) begin fails++; $display("FAIL sub_decode: got exc %b type %0d f7 %h want 000 0 20", out_exception_vector, out_instr_type, out_funct7); end
        checks++; if ({out_rs1, out_rs2, out_rd} !== {5'd1, 5'd2, 5'd3}) begin fails++; $display("FAIL sub_regs: got %0d %0d %0d want 1 2 3", out_rs1, out_rs2, out_rd); end
        deq();
    endtask

    task automatic test_reset_override();
        enq(32'h0050_0093, 32'h900, 1'b0, 3'b000);
        enq(32'h0050_0093, 32'h904, 1'b0, 3'b000);
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1;
        tick();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        checks++; if ({count, out_valid, out_pc} !== {3'd0, 1'b0, 32'h0}) begin fails++; $display("FAIL reset_override: got count %0d valid %b pc %h want 0 0 0", count, out_valid, out_pc); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_decode_formats();
        test_fill_wrap();
        test_back_to_back();
        test_system();
        test_exceptions();
        test_flush();
        test_mul();
        test_reset_override();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/decode_queue.md
# decode_queue

Parametrised decode stage with an instruction buffer. It accepts raw 32-bit instructions from fetch over a valid/ready handshake and decodes them at enqueue. Decoded entries are held in a DEPTH-entry circular queue and presented in order to the issue/rename stage over a second valid/ready handshake. Beyond plain decoding, it adds illegal-opcode detection, fetch-exception propagation, flush, and back-pressure.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥ 2.
- `XLEN`, 32: PC width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: discard all queued entries (branch mispredict or exception redirect).
- `in_valid` in 1: fetch presents an instruction.
- `in_ready` out 1: queue can accept one instruction.
- `in_instr` in 32: raw instruction.
- `in_pc` in XLEN: PC of `in_instr`.
- `in_supervisor_mode` in 1: privilege at fetch.
- `in_exception_vector` in 3: exception bits raised by fetch (bit0 = iTLB/fetch fault).
- `out_valid` out 1: head entry valid.
- `out_ready` in 1: consumer takes the head.
- `out_pc` out XLEN: head PC.
- `out_rs1`, `out_rs2`, `out_rd` out 5 each: register fields.
- `out_funct7` out 7, `out_funct3` out 3, `out_opcode` out 7: raw instruction fields.
- `out_imm` out 32: sign-extended immediate.
- `out_instr_type` out 3: `INSTR_TYPE_*` from defines2.sv.
- `out_exception_vector` out 3: bit2 privilege violation, bit1 illegal instruction, bit0 fetch fault.
- `count` out $clog2(DEPTH+1): occupied entries.

## Operation
- Decode is combinational on `in_instr` and is stored with `in_pc` into `entry[wr_ptr]` on enqueue.
- Enqueue occurs when `in_valid && in_ready`. Dequeue occurs when `out_valid && out_ready`.
- Immediate selection uses the standard formats: I for LOAD/ALU_IMM, S for STORE, B for BRANCH, U for AUIPC/LUI, J otherwise.
- `instr_type` priority, highest first:
  - IRET (SYSTEM, IRET_FUNCT3)
  - MOVRM (SYSTEM, MOVRM_FUNCT3)
  - TLBWRITE
  - MUL (ALU opcode with MUL_FUNCT7)
  - ALU (ALU, AUIPC, ALU_IMM, NOP)
  - LOAD (LOAD, LUI)
  - STORE
  - NO_WB for everything else
- Exception bits:
  - bit2 = SYSTEM opcode && !`in_supervisor_mode`.
  - bit1 = opcode not one of ALU, ALU_IMM, BRANCH, STORE, LOAD, JUMP, AUIPC, LUI, NOP, SYSTEM, TLBWRITE.
  - bit0 = `in_exception_vector[0]`.
  - bits 2:1 are also OR'd with `in_exception_vector[2:1]`.
- Any entry whose stored exception vector is nonzero gets `instr_type` forced to INSTR_TYPE_NO_WB.
- Pointer behaviour:
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - `count` increments on enqueue only, decrements on dequeue only, and is unchanged on simultaneous enqueue and dequeue.
- `flush`:
  - Next cycle, `wr_ptr = rd_ptr = 0` and `count = 0`.
  - An enqueue or dequeue in the same cycle as `flush` is discarded.
  - Entry storage is not cleared.

## Timing
- `in_ready = (count != DEPTH)`. It is registered-state only, with no combinational path from `out_ready`. When full, a simultaneous dequeue does not allow an enqueue that cycle.
- `out_valid = (count != 0)`.
- `out_*` are combinational reads of `entry[rd_ptr]`. When `out_valid = 0` the value is don't-care.
- Latency: an instruction enqueued at edge N appears at the head with `out_valid = 1` in cycle N+1, if the queue was empty. Throughput is one instruction per cycle.
- Reset values:
  - `count = 0`, pointers 0, all entry storage 0.
  - Therefore `out_valid = 0` and every `out_*` is 0.
  - `in_ready = 1`.
- `reset` overrides `flush` and both handshakes.
- The consumer may deassert `out_ready` arbitrarily; the head is held stable until dequeued or flushed.

## Configuration
- `DECODE_MUL_EN` defined: ALU opcode with MUL_FUNCT7 decodes to INSTR_TYPE_MUL.
- `DECODE_MUL_EN` undefined:
  - That encoding sets exception bit1 (illegal instruction), and `instr_type` becomes NO_WB.
  - All other ALU funct7 values decode as before.
  - The MUL type-select logic is compiled out.

## Test plan
- Reset, then enqueue ADDI x1,x0,5 (0x00500093): next cycle `out_valid = 1`, `instr_type` = ALU, `imm` = 5, `rd` = 1, exception = 0.
- Enqueue 4 instructions with `out_ready = 0` (DEPTH = 4): `in_ready = 0` after the 4th and `count = 4`. Then dequeue one per cycle: PCs come out in order and the queue wraps correctly on a further 3 enqueues.
- Enqueue and dequeue every cycle for 10 cycles at `count = 2`: `count` stays 2 and no entry is lost or duplicated.
- SYSTEM instruction with `in_supervisor_mode = 0`: exception = 3'b100, type NO_WB. Same instruction with `in_supervisor_mode = 1` and IRET_FUNCT3: type IRET, exception = 0.
- Opcode 0x7F: exception bit1 set. Separately, a clean instruction with `in_exception_vector = 3'b001`: output exception 3'b001, type NO_WB.
- `count = 3`, assert `flush` together with `in_valid`: next cycle `count = 0`, `out_valid = 0`, `in_ready = 1`. With `DECODE_MUL_EN` undefined, MUL x3,x1,x2 (0x022081B3): exception = 3'b010.
